// File: rtl/life_gen_ctrl_if.sv
// Bundle between the life generation controller, its user/timer sources and the 4x4 cell array.
// The controller takes the slave side; whatever drives requests and models the array takes master.
interface life_gen_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             tick;
    logic             frame;
    logic             run_mode;
    logic             step_req;
    logic             load_req;
    logic [15:0]      load_pattern;
    logic [1:0]       usr_row;
    logic [1:0]       usr_col;
    logic             usr_val;
    logic             usr_we;
    logic [15:0]      alive;
    logic [1:0]       arr_row;
    logic [1:0]       arr_col;
    logic             arr_val;
    logic             arr_we;
    logic             arr_run;
    logic             busy;
    logic [GEN_W-1:0] gen_count;
    logic             stable;

    modport master (
        output tick, frame, run_mode, step_req, load_req, load_pattern,
               usr_row, usr_col, usr_val, usr_we, alive,
        input  arr_row, arr_col, arr_val, arr_we, arr_run, busy, gen_count, stable
    );

    modport slave (
        input  tick, frame, run_mode, step_req, load_req, load_pattern,
               usr_row, usr_col, usr_val, usr_we, alive,
        output arr_row, arr_col, arr_val, arr_we, arr_run, busy, gen_count, stable
    );
endinterface

// File: rtl/life_gen_ctrl.sv
// Sequencer owning the life array write port and run strobe: user writes, 16-cell loads, generation steps.
// Define LIFE_GEN_CTRL_STALL_DETECT_EN to enable board-stable detection and tick auto-pause.
module life_gen_ctrl #(
    parameter int GEN_W      = 16,
    parameter bit FRAME_SYNC = 1'b1
) (
    input logic            clk,
    input logic            reset,
    life_gen_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_FRAME, RUN, CHECK} state_t;

    state_t           state;
    logic             pend;
    logic [3:0]       idx;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic             val_q;
    logic             we_q;
    logic             run_q;
    logic             busy_q;
    logic [GEN_W-1:0] gen_q;
    logic             pause;
    logic             pend_set;

    assign pend_set = (bus.tick & bus.run_mode & ~pause) | bus.step_req;

    // arr_run is raised on entry to RUN so the array updates at the end of RUN
    // and CHECK already sees the new board.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= 1'b0;
            idx    <= 4'd0;
            row_q  <= 2'd0;
            col_q  <= 2'd0;
            val_q  <= 1'b0;
            we_q   <= 1'b0;
            run_q  <= 1'b0;
            busy_q <= 1'b0;
            gen_q  <= '0;
        end else begin
            we_q  <= 1'b0;
            run_q <= 1'b0;
            pend  <= pend | pend_set;
            case (state)
                IDLE: begin
                    if (bus.load_req) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                        idx    <= 4'd0;
                        gen_q  <= '0;
                        pend   <= pend_set;
                    end else if (bus.usr_we) begin
                        we_q  <= 1'b1;
                        row_q <= bus.usr_row;
                        col_q <= bus.usr_col;
                        val_q <= bus.usr_val;
                    end else if (pend) begin
                        busy_q <= 1'b1;
                        if (FRAME_SYNC) begin
                            state <= WAIT_FRAME;
                        end else begin
                            state <= RUN;
                            run_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    we_q  <= 1'b1;
                    row_q <= idx[3:2];
                    col_q <= idx[1:0];
                    val_q <= bus.load_pattern[idx];
                    idx   <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    if (bus.load_req) begin
                        state <= LOAD;
                        idx   <= 4'd0;
                        gen_q <= '0;
                        pend  <= pend_set;
                    end else if (bus.frame) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end
                end
                RUN: begin
                    gen_q <= gen_q + GEN_W'(1);
                    pend  <= pend_set;
                    state <= CHECK;
                end
                CHECK: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LIFE_GEN_CTRL_STALL_DETECT_EN
    logic [15:0] snapshot;
    logic        stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot <= 16'd0;
            stable_q <= 1'b0;
        end else begin
            if (state == RUN)
                snapshot <= bus.alive;
            if ((state == IDLE || state == WAIT_FRAME) && bus.load_req)
                stable_q <= 1'b0;
            else if (state == IDLE && bus.usr_we)
                stable_q <= 1'b0;
            else if (state == CHECK)
                stable_q <= (bus.alive == snapshot);
        end
    end

    assign pause      = stable_q & bus.run_mode;
    assign bus.stable = stable_q;
`else
    assign pause      = 1'b0;
    assign bus.stable = 1'b0;
`endif

    assign bus.arr_row   = row_q;
    assign bus.arr_col   = col_q;
    assign bus.arr_val   = val_q;
    assign bus.arr_we    = we_q;
    assign bus.arr_run   = run_q;
    assign bus.busy      = busy_q;
    assign bus.gen_count = gen_q;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// Directed bench for life_gen_ctrl: a frame-synced 16-bit instance and a free-issuing 4-bit-counter instance.
module tb_life_gen_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

`ifdef LIFE_GEN_CTRL_STALL_DETECT_EN
    localparam bit EXP_STALL = 1'b1;
`else
    localparam bit EXP_STALL = 1'b0;
`endif

    always #5 clk = ~clk;

    life_gen_ctrl_if #(.GEN_W(16)) b();
    life_gen_ctrl_if #(.GEN_W(4))  b4();

    life_gen_ctrl #(.GEN_W(16), .FRAME_SYNC(1'b1)) dut  (.clk(clk), .reset(reset), .bus(b));
    life_gen_ctrl #(.GEN_W(4),  .FRAME_SYNC(1'b0)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        total++;
        if ({b.arr_row, b.arr_col, b.arr_val, b.arr_we, b.arr_run, b.busy, b.stable} !== 9'd0 ||
            b.gen_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs got we=%b run=%b busy=%b gen=%0d want all 0",
                     b.arr_we, b.arr_run, b.busy, b.gen_count);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] pat;
        logic [5:0]  got;
        logic [5:0]  exp;
        b.load_pattern = 16'hFFFF;
        b.load_req = 1'b1;
        cyc();
        b.load_req = 1'b0;
        repeat (7) cyc();
        total++;
        if (b.arr_we !== 1'b1 || b.busy !== 1'b1) begin
            bad++;
            $display("FAIL load_in_progress got we=%b busy=%b want 1 1", b.arr_we, b.busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({b.arr_we, b.arr_run, b.busy, b.arr_row, b.arr_col, b.arr_val} !== 8'd0) begin
            bad++;
            $display("FAIL reset_abort got we=%b busy=%b row=%0d col=%0d want 0", b.arr_we, b.busy, b.arr_row, b.arr_col);
        end
        cyc();
        reset = 1'b0;
        cyc();
        total++;
        if (b.arr_we !== 1'b0 || b.busy !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_idle got we=%b busy=%b want 0 0", b.arr_we, b.busy);
        end
        pat = 16'hA5A5;
        b.load_pattern = pat;
        b.load_req = 1'b1;
        cyc();
        b.load_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            got = {b.arr_we, b.arr_row, b.arr_col, b.arr_val};
            exp = {1'b1, 4'(i), pat[i]};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL load_write_%0d got %b want %b", i, got, exp);
            end
        end
        total++;
        if (b.busy !== 1'b0 || b.gen_count !== 16'd0) begin
            bad++;
            $display("FAIL load_end got busy=%b gen=%0d want 0 0", b.busy, b.gen_count);
        end
        cyc();
        total++;
        if (b.arr_we !== 1'b0) begin
            bad++;
            $display("FAIL load_no_extra_write got %b want 0", b.arr_we);
        end
    endtask

    task automatic test_frame_sync();
        int  runs = 0;
        bit  busy_ok = 1'b1;
        b.step_req = 1'b1;
        cyc();
        b.step_req = 1'b0;
        cyc();
        total++;
        if (b.busy !== 1'b1) begin
            bad++;
            $display("FAIL step_busy got %b want 1", b.busy);
        end
        for (int i = 0; i < 48; i++) begin
            cyc();
            runs += int'(b.arr_run);
            if (b.busy !== 1'b1) busy_ok = 1'b0;
        end
        total++;
        if (busy_ok !== 1'b1 || runs != 0) begin
            bad++;
            $display("FAIL wait_frame_hold got busy_ok=%b runs=%0d want 1 0", busy_ok, runs);
        end
        b.frame = 1'b1;
        cyc();
        b.frame = 1'b0;
        runs += int'(b.arr_run);
        total++;
        if (b.arr_run !== 1'b1 || b.arr_we !== 1'b0) begin
            bad++;
            $display("FAIL run_after_frame got run=%b we=%b want 1 0", b.arr_run, b.arr_we);
        end
        cyc();
        runs += int'(b.arr_run);
        total++;
        if (b.gen_count !== 16'd1 || b.busy !== 1'b1) begin
            bad++;
            $display("FAIL check_state got gen=%0d busy=%b want 1 1", b.gen_count, b.busy);
        end
        cyc();
        total++;
        if (b.busy !== 1'b0) begin
            bad++;
            $display("FAIL back_idle got busy=%b want 0", b.busy);
        end
        repeat (5) begin
            cyc();
            runs += int'(b.arr_run);
        end
        total++;
        if (runs != 1) begin
            bad++;
            $display("FAIL single_run got %0d want 1", runs);
        end
    endtask

    task automatic test_frame_ignored();
        int runs = 0;
        b.frame = 1'b1;
        cyc();
        b.frame = 1'b0;
        b.step_req = 1'b1;
        cyc();
        b.step_req = 1'b0;
        repeat (6) begin
            cyc();
            runs += int'(b.arr_run);
        end
        total++;
        if (runs != 0) begin
            bad++;
            $display("FAIL early_frame_forgotten got runs=%0d want 0", runs);
        end
        b.frame = 1'b1;
        cyc();
        b.frame = 1'b0;
        cyc();
        cyc();
        total++;
        if (b.gen_count !== 16'd2) begin
            bad++;
            $display("FAIL gen_after_second got %0d want 2", b.gen_count);
        end
    endtask

    task automatic test_load_vs_user();
        logic [5:0] got;
        logic [5:0] exp;
        b.load_pattern = 16'h0000;
        b.usr_row = 2'd2;
        b.usr_col = 2'd3;
        b.usr_val = 1'b1;
        b.usr_we = 1'b1;
        b.load_req = 1'b1;
        cyc();
        b.load_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            got = {b.arr_we, b.arr_row, b.arr_col, b.arr_val};
            exp = {1'b1, 4'(i), 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL load_wins_%0d got %b want %b", i, got, exp);
            end
        end
        cyc();
        got = {b.arr_we, b.arr_row, b.arr_col, b.arr_val};
        total++;
        if (got !== 6'b1_10_11_1) begin
            bad++;
            $display("FAIL user_after_load got %b want 110111", got);
        end
        b.usr_we = 1'b0;
        cyc();
        total++;
        if (b.arr_we !== 1'b0 || b.gen_count !== 16'd0) begin
            bad++;
            $display("FAIL user_released got we=%b gen=%0d want 0 0", b.arr_we, b.gen_count);
        end
    endtask

    task automatic test_run_mode_collapse();
        int runs = 0;
        b.run_mode = 1'b1;
        b.tick = 1'b1;
        cyc();
        b.tick = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            b.tick = (i == 2 || i == 5);
            cyc();
            runs += int'(b.arr_run);
        end
        b.tick = 1'b0;
        b.frame = 1'b1;
        cyc();
        b.frame = 1'b0;
        runs += int'(b.arr_run);
        repeat (8) begin
            cyc();
            runs += int'(b.arr_run);
        end
        b.run_mode = 1'b0;
        total++;
        if (runs != 1 || b.gen_count !== 16'd1) begin
            bad++;
            $display("FAIL tick_collapse got runs=%0d gen=%0d want 1 1", runs, b.gen_count);
        end
    endtask

    task automatic test_stall();
        int runs = 0;
        b.alive = 16'h0033;
        b.load_pattern = 16'h0033;
        b.load_req = 1'b1;
        cyc();
        b.load_req = 1'b0;
        repeat (17) cyc();
        b.run_mode = 1'b1;
        b.tick = 1'b1;
        cyc();
        b.tick = 1'b0;
        cyc();
        b.frame = 1'b1;
        cyc();
        b.frame = 1'b0;
        cyc();
        cyc();
        total++;
        if (b.gen_count !== 16'd1 || b.stable !== EXP_STALL) begin
            bad++;
            $display("FAIL stable_after_gen got gen=%0d stable=%b want 1 %b", b.gen_count, b.stable, EXP_STALL);
        end
        for (int i = 0; i < 20; i++) begin
            b.tick = (i % 4 == 0);
            b.frame = (i % 4 == 2);
            cyc();
            runs += int'(b.arr_run);
        end
        b.tick = 1'b0;
        b.run_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b.frame = (i % 2 == 0);
            cyc();
        end
        b.frame = 1'b0;
        total++;
        if ((runs == 0) !== EXP_STALL) begin
            bad++;
            $display("FAIL auto_pause got runs=%0d want paused=%b", runs, EXP_STALL);
        end
        b.step_req = 1'b1;
        cyc();
        b.step_req = 1'b0;
        cyc();
        b.frame = 1'b1;
        cyc();
        b.frame = 1'b0;
        total++;
        if (b.arr_run !== 1'b1) begin
            bad++;
            $display("FAIL step_while_stable got run=%b want 1", b.arr_run);
        end
        cyc();
        cyc();
        total++;
        if (b.stable !== EXP_STALL) begin
            bad++;
            $display("FAIL stable_kept got %b want %b", b.stable, EXP_STALL);
        end
        b.usr_row = 2'd0;
        b.usr_col = 2'd0;
        b.usr_val = 1'b1;
        b.usr_we = 1'b1;
        cyc();
        b.usr_we = 1'b0;
        total++;
        if (b.arr_we !== 1'b1 || b.stable !== 1'b0) begin
            bad++;
            $display("FAIL user_clears_stable got we=%b stable=%b want 1 0", b.arr_we, b.stable);
        end
    endtask

    task automatic test_wrap();
        int runs = 0;
        for (int s = 0; s < 16; s++) begin
            b4.step_req = 1'b1;
            cyc();
            b4.step_req = 1'b0;
            cyc();
            runs += int'(b4.arr_run);
            if (s == 0) begin
                total++;
                if (b4.arr_run !== 1'b1 || b4.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL nosync_latency got run=%b busy=%b want 1 1", b4.arr_run, b4.busy);
                end
            end
            cyc();
            runs += int'(b4.arr_run);
            cyc();
            if (s == 14) begin
                total++;
                if (b4.gen_count !== 4'd15) begin
                    bad++;
                    $display("FAIL gen_15 got %0d want 15", b4.gen_count);
                end
            end
        end
        total++;
        if (b4.gen_count !== 4'd0 || runs != 16) begin
            bad++;
            $display("FAIL gen_wrap got gen=%0d runs=%0d want 0 16", b4.gen_count, runs);
        end
    endtask

    initial begin
        {b.tick, b.frame, b.run_mode, b.step_req, b.load_req, b.usr_val, b.usr_we} = '0;
        {b.usr_row, b.usr_col} = '0;
        b.load_pattern = '0;
        b.alive = '0;
        {b4.tick, b4.frame, b4.run_mode, b4.step_req, b4.load_req, b4.usr_val, b4.usr_we} = '0;
        {b4.usr_row, b4.usr_col} = '0;
        b4.load_pattern = '0;
        b4.alive = '0;
        test_reset();
        test_reset_mid_load();
        test_frame_sync();
        test_frame_ignored();
        test_load_vs_user();
        test_run_mode_collapse();
        test_stall();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
- Sequencer that sits between user/timer inputs and the 4x4 life cell array.
- Owns the array's write port and run strobe. Arbitrates single-cell user writes, bulk 16-cell pattern loads and generation steps.
- Optionally aligns generation steps to the display frame boundary so a frame never shows a half-updated board.
- Counts generations and reports when the board has stopped changing.

Parameters:
- GEN_W, 16, width of the generation counter.
- FRAME_SYNC, 1, 1 = a pending step waits for a frame pulse; 0 = the step issues as soon as the controller is idle.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- tick  in  1  one-cycle pulse from the generation timer
- frame  in  1  one-cycle pulse at the display frame boundary
- run_mode  in  1  1 = free-run, each tick requests one generation
- step_req  in  1  one-cycle pulse; requests a single generation
- load_req  in  1  one-cycle pulse; loads load_pattern into the array
- load_pattern  in  16  bit [r*4+c] = cell (row r, col c)
- usr_row  in  2  user write row
- usr_col  in  2  user write column
- usr_val  in  1  user write value
- usr_we  in  1  user write request (level)
- alive  in  16  current array state, same bit mapping as load_pattern
- arr_row  out  2  row driven to the array
- arr_col  out  2  column driven to the array
- arr_val  out  1  value driven to the array
- arr_we  out  1  array write enable
- arr_run  out  1  one-cycle generation strobe to the array
- busy  out  1  high in LOAD, WAIT_FRAME, RUN and CHECK
- gen_count  out  GEN_W  number of generations since the last reset or load
- stable  out  1  last generation left the board unchanged

Behaviour:
- Reset values: all outputs 0, state IDLE, pend = 0, idx = 0, snapshot = 0. Reset asserted mid-LOAD aborts the load immediately.
- pend (step pending) is set by (tick & run_mode) | step_req. Multiple requests while pend = 1 collapse into one.
- pend is cleared in the cycle arr_run is asserted. If a set and a clear occur in the same cycle, set wins.
- All array-facing outputs are registered. Command to array effect = 1 cycle.
- States:
  - IDLE:
    - Priority 1, load_req: go to LOAD, idx = 0, clear gen_count and stable, clear pend.
    - Priority 2, usr_we: drive arr_we = 1 with arr_row/arr_col/arr_val = usr_row/usr_col/usr_val for one cycle; stay in IDLE. The write repeats every cycle while usr_we is held.
    - Priority 3, pend: go to WAIT_FRAME if FRAME_SYNC = 1, else go to RUN.
  - LOAD: each cycle drive arr_we = 1, arr_row = idx[3:2], arr_col = idx[1:0], arr_val = load_pattern[idx], then idx = idx + 1.
    - idx = 15 is the last write; next state IDLE. A load takes exactly 16 cycles.
    - load_pattern is sampled per cycle and must be held stable by the source during the load.
    - usr_we and load_req are ignored during LOAD. step_req and tick may set pend.
  - WAIT_FRAME: on frame, go to RUN. usr_we is ignored here. load_req aborts the wait: go to LOAD, pend cleared.
  - RUN: one cycle. Latch snapshot = alive, arr_run = 1, gen_count = gen_count + 1 (wraps to 0 past all-ones), clear pend. Next state CHECK.
  - CHECK: one cycle, allows the array to update. Compare alive to snapshot for the stall feature. Next state IDLE.
- Minimum spacing between arr_run pulses = 3 cycles.
- arr_we and arr_run are never high in the same cycle.
- frame arriving while not in WAIT_FRAME is ignored (not remembered).

Optional Feature:
- Macro: LIFE_GEN_CTRL_STALL_DETECT_EN.
- Defined:
  - In CHECK, stable is set to 1 if alive == snapshot, else cleared.
  - While stable = 1 and run_mode = 1, tick no longer sets pend (auto-pause).
  - step_req still sets pend.
  - stable is cleared by load_req, by any user write, or by a CHECK that sees a change.
- Not defined: stable is tied to 0 and there is no auto-pause.

Test Plan:
- Reset during LOAD at idx = 7 -> all outputs 0 next cycle; after release, a fresh load_req with 0xA5A5 -> 16 writes, cell r*4+c written with bit [r*4+c], gen_count = 0.
- FRAME_SYNC = 1, step_req then frame 50 cycles later -> exactly one arr_run, in the cycle after frame; gen_count 0 -> 1; busy high from the step through CHECK.
- load_req and usr_we asserted in the same cycle while in IDLE -> load wins; no user write during the 16 load cycles; the user write is performed in the first IDLE cycle after the load.
- run_mode = 1, 3 ticks while waiting for frame -> one arr_run only; gen_count + 1.
- GEN_W = 4 with 16 steps issued -> gen_count wraps to 0.
- With LIFE_GEN_CTRL_STALL_DETECT_EN, load a 2x2 block (0x0033), run_mode = 1, board unchanged -> after the first generation stable = 1, and further ticks produce no arr_run; usr_we clears stable.
